// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types, select codes and match helper for the ID-stage hazard controller.
package id_hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned WORD  = 32;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [SEL_W-1:0] FWD_RF  = 2'd0;
   localparam logic [SEL_W-1:0] FWD_EX  = 2'd1;
   localparam logic [SEL_W-1:0] FWD_MEM = 2'd2;
   localparam logic [SEL_W-1:0] FWD_WB  = 2'd3;

   typedef logic [REG_W-1:0] reg_t;

   // Destination of an in-flight instruction in one pipeline stage
   typedef struct packed {
      reg_t dest;
      logic wb_en;
   } wb_tgt_t;

   // Register 0 is hardwired, so it never matches a producer
   function automatic logic dest_match(wb_tgt_t tgt, reg_t r);
      return tgt.wb_en && (tgt.dest == r) && (r != '0);
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID decode / pipeline-register bundle seen by the hazard controller.
interface id_hazard_ctrl_if;
   import id_hazard_ctrl_pkg::*;

   reg_t             id_rs;
   reg_t             id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             id_is_branch;
   logic             id_branch_taken;
   logic             id_jump_taken;
   logic             id_terminate;
   wb_tgt_t          ex_tgt;
   logic             ex_mem_r;
   wb_tgt_t          mem_tgt;
   logic             mem_mem_r;
   wb_tgt_t          wb_tgt;
   logic             stall;
   logic             flush_if;
   logic [SEL_W-1:0] branch_a1_sel;
   logic [SEL_W-1:0] branch_a2_sel;
   logic             halt;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
             id_branch_taken, id_jump_taken, id_terminate,
             ex_tgt, ex_mem_r, mem_tgt, mem_mem_r, wb_tgt,
      input  stall, flush_if, branch_a1_sel, branch_a2_sel, halt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
             id_branch_taken, id_jump_taken, id_terminate,
             ex_tgt, ex_mem_r, mem_tgt, mem_mem_r, wb_tgt,
      output stall, flush_if, branch_a1_sel, branch_a2_sel, halt
   );

endinterface

// File: rtl/id_hazard_ctrl_fwd_select.sv
// Branch-operand forwarding select for one source register, youngest producer wins.
module id_hazard_ctrl_fwd_select
   import id_hazard_ctrl_pkg::*;
(
   input  reg_t             reg_i,
   input  wb_tgt_t          ex_i,
   input  wb_tgt_t          mem_i,
   input  wb_tgt_t          wb_i,
   output logic [SEL_W-1:0] sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (dest_match(ex_i, reg_i)) begin
         sel_o = FWD_EX;
      end else if (dest_match(mem_i, reg_i)) begin
         sel_o = FWD_MEM;
      end else if (dest_match(wb_i, reg_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: stall/flush generation, branch forwarding selects, end-of-program drain.
// Optional HAZARD_STATS_EN adds saturating stall-cycle and flush counters.
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   id_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [WORD-1:0] stall_cycles_o,
   output logic [WORD-1:0] flush_count_o
`endif
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [SEL_W-1:0] sel_a1, sel_a2;
   logic [1:0]       need_rs, need_rt, need;
   logic             stall_c, flush_c, halt_c;

   // 2 = load in EX feeding a branch, 1 = one more cycle needed, 0 = proceed
   function automatic logic [1:0] hazard_need(reg_t r, logic use_r, logic is_br,
                                               wb_tgt_t ex, logic ex_mr,
                                               wb_tgt_t mem, logic mem_mr);
      logic [1:0] n;
      n = 2'd0;
      if (is_br) begin
         if (dest_match(ex, r) && ex_mr) begin
            n = 2'd2;
         end else if (dest_match(mem, r) && mem_mr) begin
            n = 2'd1;
         end
      end else if (use_r && dest_match(ex, r) && ex_mr) begin
         n = 2'd1;
      end
      return n;
   endfunction

   id_hazard_ctrl_fwd_select u_fwd_a1 (
      .reg_i (hz.id_rs),
      .ex_i  (hz.ex_tgt),
      .mem_i (hz.mem_tgt),
      .wb_i  (hz.wb_tgt),
      .sel_o (sel_a1)
   );

   id_hazard_ctrl_fwd_select u_fwd_a2 (
      .reg_i (hz.id_rt),
      .ex_i  (hz.ex_tgt),
      .mem_i (hz.mem_tgt),
      .wb_i  (hz.wb_tgt),
      .sel_o (sel_a2)
   );

   always_comb begin
      need_rs = hazard_need(hz.id_rs, hz.id_uses_rs | hz.id_is_branch, hz.id_is_branch,
                            hz.ex_tgt, hz.ex_mem_r, hz.mem_tgt, hz.mem_mem_r);
      need_rt = hazard_need(hz.id_rt, hz.id_uses_rt | hz.id_is_branch, hz.id_is_branch,
                            hz.ex_tgt, hz.ex_mem_r, hz.mem_tgt, hz.mem_mem_r);
      need    = (need_rs > need_rt) ? need_rs : need_rt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter leaves STALL/DRAIN on the cycle it would reach zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (need == 2'd2) begin
               state_d = ST_STALL;
               cnt_d   = CNT_W'(1);
            end else if ((need == 2'd0) && hz.id_terminate) begin
               state_d = ST_DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end
         end
         ST_STALL, ST_DRAIN: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = (state_q == ST_STALL) ? ST_RUN : ST_HALT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall_c          = 1'b0;
      flush_c          = 1'b0;
      halt_c           = 1'b0;
      hz.branch_a1_sel = FWD_RF;
      hz.branch_a2_sel = FWD_RF;
      if (!rst_i) begin
         case (state_q)
            ST_RUN: begin
               stall_c          = (need != 2'd0) || hz.id_terminate;
               flush_c          = (need == 2'd0) && !hz.id_terminate &&
                                  (hz.id_branch_taken || hz.id_jump_taken);
               hz.branch_a1_sel = sel_a1;
               hz.branch_a2_sel = sel_a2;
            end
            ST_STALL, ST_DRAIN: begin
               stall_c          = 1'b1;
               hz.branch_a1_sel = sel_a1;
               hz.branch_a2_sel = sel_a2;
            end
            default: begin
               stall_c = 1'b1;
               halt_c  = 1'b1;
            end
         endcase
      end
   end

   assign hz.stall    = stall_c;
   assign hz.flush_if = flush_c;
   assign hz.halt     = halt_c;

`ifdef HAZARD_STATS_EN
   logic [WORD-1:0] stall_cycles_q, flush_count_q;

   // Drain/halt stalls are not hazard cost, so they are excluded
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (stall_c && ((state_q == ST_RUN) || (state_q == ST_STALL)) &&
             (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + WORD'(1);
         end
         if (flush_c && (flush_count_q != '1)) begin
            flush_count_q <= flush_count_q + WORD'(1);
         end
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed cases then randomized traffic vs a reference model.
module tb_id_hazard_ctrl;
   import id_hazard_ctrl_pkg::*;

   localparam int DRAIN = 3;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs, rt;
      logic       uses_rs, uses_rt, is_branch, br_taken, j_taken, term;
      logic [4:0] ex_dest;
      logic       ex_wb, ex_mr;
      logic [4:0] mem_dest;
      logic       mem_wb, mem_mr;
      logic [4:0] wb_dest;
      logic       wb_en;
   } stim_t;

   typedef struct packed {
      logic       stall, flush, halt;
      logic [1:0] a1, a2;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   id_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (bus)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles_o (stall_cycles),
      .flush_count_o  (flush_count)
`endif
   );

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cycle = 0;

   // Reference model: extra forced-stall and drain cycles still owed, plus halted flag
   int m_hold   = 0;
   int m_drain  = 0;
   bit m_halted = 0;

   function automatic int m_fwd(logic [4:0] r, stim_t s);
      if (r == 0) return 0;
      if (s.ex_wb && s.ex_dest == r) return 1;
      if (s.mem_wb && s.mem_dest == r) return 2;
      if (s.wb_en && s.wb_dest == r) return 3;
      return 0;
   endfunction

   function automatic int m_need(logic [4:0] r, logic use_r, stim_t s);
      bit ex_load, mem_load;
      if (r == 0) return 0;
      ex_load  = s.ex_wb && s.ex_mr && s.ex_dest == r;
      mem_load = s.mem_wb && s.mem_mr && s.mem_dest == r;
      if (s.is_branch) return ex_load ? 2 : (mem_load ? 1 : 0);
      return (use_r && ex_load) ? 1 : 0;
   endfunction

   task automatic cyc(input stim_t s);
      exp_t e;
      int   n;
      @(posedge clk);
      #1;
      rst                 = s.rst;
      bus.id_rs           = s.rs;
      bus.id_rt           = s.rt;
      bus.id_uses_rs      = s.uses_rs;
      bus.id_uses_rt      = s.uses_rt;
      bus.id_is_branch    = s.is_branch;
      bus.id_branch_taken = s.br_taken;
      bus.id_jump_taken   = s.j_taken;
      bus.id_terminate    = s.term;
      bus.ex_tgt.dest     = s.ex_dest;
      bus.ex_tgt.wb_en    = s.ex_wb;
      bus.ex_mem_r        = s.ex_mr;
      bus.mem_tgt.dest    = s.mem_dest;
      bus.mem_tgt.wb_en   = s.mem_wb;
      bus.mem_mem_r       = s.mem_mr;
      bus.wb_tgt.dest     = s.wb_dest;
      bus.wb_tgt.wb_en    = s.wb_en;
      e = '0;
      if (s.rst) begin
         m_hold = 0; m_drain = 0; m_halted = 0;
      end else if (m_halted) begin
         e.stall = 1; e.halt = 1;
      end else begin
         e.a1 = 2'(m_fwd(s.rs, s));
         e.a2 = 2'(m_fwd(s.rt, s));
         if (m_drain > 0) begin
            e.stall = 1;
            m_drain--;
            if (m_drain == 0) m_halted = 1;
         end else if (m_hold > 0) begin
            e.stall = 1;
            m_hold--;
         end else begin
            n = m_need(s.rs, s.uses_rs | s.is_branch, s);
            if (m_need(s.rt, s.uses_rt | s.is_branch, s) > n) n = m_need(s.rt, s.uses_rt | s.is_branch, s);
            if (n > 0) begin
               e.stall = 1;
               if (n == 2) m_hold = 1;
            end else if (s.term) begin
               e.stall = 1;
               m_drain = DRAIN - 1;
            end else if (s.br_taken || s.j_taken) begin
               e.flush = 1;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, got, want);
      end
   endtask

   // Monitor: outputs are combinational, so each driven cycle presents one result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",         {1'b0, bus.stall},    {1'b0, e.stall});
            chk("flush_if",      {1'b0, bus.flush_if}, {1'b0, e.flush});
            chk("halt",          {1'b0, bus.halt},     {1'b0, e.halt});
            chk("branch_a1_sel", bus.branch_a1_sel,    e.a1);
            chk("branch_a2_sel", bus.branch_a2_sel,    e.a2);
         end
      end
   end

   initial begin
      stim_t s;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
      bus.id_is_branch = 0; bus.id_branch_taken = 0; bus.id_jump_taken = 0;
      bus.id_terminate = 0; bus.ex_tgt = '0; bus.ex_mem_r = 0;
      bus.mem_tgt = '0; bus.mem_mem_r = 0; bus.wb_tgt = '0;

      s = '0; s.rst = 1;
      cyc(s); cyc(s);

      // ALU producer feeding a branch
      s = '0; s.ex_dest = 5; s.ex_wb = 1; s.is_branch = 1; s.rs = 5;
      cyc(s);

      // Branch after load: EX load, then MEM, then WB
      s = '0; s.is_branch = 1; s.rt = 8; s.ex_dest = 8; s.ex_wb = 1; s.ex_mr = 1;
      cyc(s);
      s.ex_wb = 0; s.ex_mr = 0; s.mem_dest = 8; s.mem_wb = 1; s.mem_mr = 1;
      cyc(s);
      s.mem_wb = 0; s.mem_mr = 0; s.wb_dest = 8; s.wb_en = 1;
      cyc(s);

      // Load-use on a non-branch
      s = '0; s.uses_rs = 1; s.rs = 3; s.ex_dest = 3; s.ex_wb = 1; s.ex_mr = 1;
      cyc(s);
      s.ex_wb = 0; s.ex_mr = 0; s.mem_dest = 3; s.mem_wb = 1; s.mem_mr = 1;
      cyc(s);

      // Priority across stages and register 0
      s = '0; s.is_branch = 1; s.rs = 9; s.ex_dest = 9; s.mem_dest = 9; s.wb_dest = 9;
      s.ex_wb = 1; s.mem_wb = 1; s.wb_en = 1;
      cyc(s);
      s.ex_wb = 0;
      cyc(s);
      s = '0; s.is_branch = 1; s.ex_wb = 1; s.ex_mr = 1; s.mem_wb = 1; s.wb_en = 1;
      cyc(s);

      // Taken jump, then jump together with terminate, drain and halt, then reset
      s = '0; s.j_taken = 1;
      cyc(s);
      s.term = 1;
      cyc(s);
      s = '0; s.br_taken = 1;
      repeat (5) cyc(s);
      s = '0; s.rst = 1;
      cyc(s);
      s = '0;
      cyc(s);

      // Randomized traffic over a small register window to provoke matches
      for (int i = 0; i < 4000; i++) begin
         s.rst       = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0);
         s.rs        = 5'($urandom_range(0, 3));
         s.rt        = 5'($urandom_range(0, 3));
         s.uses_rs   = 1'($urandom);
         s.uses_rt   = 1'($urandom);
         s.is_branch = 1'($urandom);
         s.br_taken  = 1'($urandom);
         s.j_taken   = ($urandom_range(0, 3) == 0);
         s.term      = ($urandom_range(0, 39) == 0);
         s.ex_dest   = 5'($urandom_range(0, 3));
         s.ex_wb     = 1'($urandom);
         s.ex_mr     = 1'($urandom);
         s.mem_dest  = 5'($urandom_range(0, 3));
         s.mem_wb    = 1'($urandom);
         s.mem_mr    = 1'($urandom);
         s.wb_dest   = 5'($urandom_range(0, 3));
         s.wb_en     = 1'($urandom);
         cyc(s);
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Hazard and sequencing controller for the decode (ID) stage of the 5-stage pipeline.
- Generates the ID stall, the IF/ID flush on taken branch/jump, and the 2-bit forwarding selects for the branch-compare operand muxes in ID.
- Runs the end-of-program drain: after a terminate instruction, fetch is frozen until in-flight writebacks retire, then halt is raised.
- Sits beside ID_stage; inputs come from ID decode and the EX/MEM/WB pipeline registers.

Parameters:
- DRAIN_CYCLES, 3: cycles stall is held after terminate before halt asserts (range 1..7).
- CNT_W, 3: width of the internal stall/drain counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_rs  in  5  ID instruction[25:21].
- id_rt  in  5  ID instruction[20:16].
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID instruction is a branch or jr; its operands are needed in ID.
- id_branch_taken  in  1  branch taken, from ID control.
- id_jump_taken  in  1  jump taken, from ID control.
- id_terminate  in  1  ID instruction is terminate.
- ex_dest  in  5  destination register of the instruction in EX.
- ex_wb_en  in  1  instruction in EX writes a register.
- ex_mem_r  in  1  instruction in EX is a load.
- mem_dest  in  5  destination register of the instruction in MEM.
- mem_wb_en  in  1  instruction in MEM writes a register.
- mem_mem_r  in  1  instruction in MEM is a load.
- wb_dest  in  5  destination register of the instruction in WB.
- wb_en  in  1  instruction in WB writes a register.
- stall  out  1  freeze PC and IF/ID; inject bubble into ID/EX.
- flush_if  out  1  clear IF/ID next edge.
- branch_a1_sel  out  2  branch operand 1 mux select.
- branch_a2_sel  out  2  branch operand 2 mux select.
- halt  out  1  pipeline drained; sticky.

Behaviour:
- Match definitions:
  - matchX(r) = X_wb_en && X_dest==r && r!=0, for X in {ex, mem, wb}.
  - use_rs = id_uses_rs || id_is_branch; use_rt = id_uses_rt || id_is_branch.
- Select encoding: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB. Priority EX > MEM > WB.
  - branch_a1_sel is computed on id_rs, branch_a2_sel on id_rt.
  - Both are combinational and forced to 0 while rst=1 or state=HALT.
- Hazard need (computed in RUN only, rs and rt evaluated independently; need = max):
  - 2: id_is_branch && matchEX(r) && ex_mem_r.
  - 1: id_is_branch && matchMEM(r) && mem_mem_r.
  - 1: !id_is_branch && use && matchEX(r) && ex_mem_r (load-use).
  - 0: all other cases.
- FSM states: RUN, STALL, DRAIN, HALT. Reset state RUN, cnt=0.
- RUN:
  - need>0: stall=1 this cycle. If need==2, go to STALL with cnt=1; else stay in RUN and re-evaluate next cycle.
  - need==0 && id_terminate: stall=1, go to DRAIN with cnt=DRAIN_CYCLES-1.
  - need==0 && (id_branch_taken || id_jump_taken): flush_if=1 for exactly that cycle.
  - Terminate has priority over a flush in the same cycle; flush_if=0 then.
- STALL:
  - stall=1, flush_if=0; branch/jump inputs are ignored.
  - cnt decrements each cycle; at cnt==0 go to RUN, where hazards are re-evaluated (load now in MEM, need 1 or 0).
- DRAIN:
  - stall=1, flush_if=0; all inputs are ignored.
  - cnt decrements; at cnt==0 go to HALT.
- HALT: stall=1, halt=1 held until rst. No exit except reset.
- Reset values: stall=0, flush_if=0, halt=0, selects 0.
- rst in any state returns to RUN, cnt=0, next cycle.
- Register 0 never forwarded and never causes a stall.
- Sole registered state: FSM state + cnt. stall/flush_if are combinational from state and inputs; halt is decoded from state.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles [31:0] and flush_count [31:0].
  - stall_cycles increments on every cycle stall=1 in RUN or STALL; DRAIN and HALT are excluded.
  - flush_count increments on every flush_if=1.
  - Both saturate at 32'hffffffff and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package / constants.v:
  - FSM state encodings (2-bit).
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB select codes.
  - `WORD.
- One natural sub-module, fwd_select: combinational, instantiated once per operand. Inputs are register, EX/MEM/WB dest and wb_en; output is the 2-bit select.

Test Plan:
- ALU producer: ex_dest=5, ex_wb_en=1, ex_mem_r=0, beq with id_rs=5 -> branch_a1_sel=1, stall=0.
- Branch after load: ex_mem_r=1, ex_dest=8, branch id_rt=8 -> stall=1 for 2 cycles; next cycle the load is in MEM with mem_mem_r=1 and stall is re-evaluated; with bubbles propagated, stall drops and branch_a2_sel=3 on the third cycle.
- Load-use non-branch: ex_mem_r=1, ex_dest=3, add with id_rs=3 -> exactly 1 stall cycle; flush_if=0.
- Multi-stage priority: ex_dest=mem_dest=wb_dest=9, all wb_en=1, id_rs=9 -> sel=1. Same case with ex_wb_en=0 -> sel=2. Any dest=0 with id_rs=0 -> sel=0, no stall.
- Taken jump: id_jump_taken=1 in RUN, no hazard -> flush_if=1 for one cycle. Same cycle with id_terminate=1 -> flush_if=0, DRAIN entered.
- Drain and halt: id_terminate=1 with DRAIN_CYCLES=3 -> stall=1 from that cycle; halt=1 on the 4th cycle and held. rst=1 -> next cycle stall=0, halt=0, state RUN.
